rvvi_frame_serializer: RTL

// - Sits between rvvisynth and the Ethernet MAC's AXI-stream TX port.
// - Buffers retired-instruction RVVI vectors in a small FIFO and wraps each one in an Ethernet header.
// - Streams each frame as 32-bit AXI-stream words.
// - Raises RVVIStall to hold the core before the FIFO can overflow.

---
 rtl/rvvi_frame_serializer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rvvi_frame_serializer.sv
// Buffers retired-instruction RVVI vectors and streams each one as an Ethernet
// frame (16-byte header + zero-padded payload) over a 32-bit AXI-stream TX port.
module rvvi_frame_serializer #(
  parameter int unsigned XLEN               = 64,
  parameter int unsigned MAX_CSRS           = 5,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter logic [31:0] RVVI_INIT_TIME_OUT = 32'd4,
  parameter logic [31:0] RVVI_PACKET_DELAY  = 32'd2,
  parameter logic [47:0] DEST_MAC           = 48'h8F54_0000_1654,
  parameter logic [47:0] SRC_MAC            = 48'h4502_1111_6843,
  parameter logic [15:0] ETHERTYPE          = 16'h88B5,
  localparam int unsigned W = 72 + 5*XLEN + MAX_CSRS*(XLEN + 16)
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_aresetn,
  input  logic          valid,
  input  logic [W-1:0]  rvvi,
  output logic          RVVIStall,
  output logic [31:0]   RvviAxiWdata,
  output logic [3:0]    RvviAxiWstrb,
  output logic          RvviAxiWlast,
  output logic          RvviAxiWvalid,
  input  logic          RvviAxiWready,
  output logic          OverflowErr,
  output logic [31:0]   FrameCount
);

  localparam int unsigned NW  = (W + 31) / 32;
  localparam int unsigned IW  = $clog2(NW + 4);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned REM = W % 32;
  localparam logic [3:0]    LAST_STRB = (REM == 0) ? 4'hF : 4'((1 << ((REM + 7) / 8)) - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NW - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  state_t        state, state_nx;
  logic [31:0]   timer, timer_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [15:0]   seq;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  logic [NW*32-1:0] padded;
  logic [127:0]     hdr_bits;
  logic [31:0]      hdr_words [4];
  logic [31:0]      pay_words [NW];

  // The head entry is popped only when its final payload word is accepted, so
  // the presented word cannot change underneath a stalled beat.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = RvviAxiWready && (state == S_PAY) && (idx == LAST_IDX);
  assign push      = valid && (!full || pop);
  assign RVVIStall = (count >= CW'(FIFO_DEPTH - 1));

  always_ff @(posedge m_axi_aclk) begin
    if (push) mem[wr_ptr] <= rvvi;
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      OverflowErr <= 1'b0;
      seq         <= '0;
      FrameCount  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (valid && full && !pop) OverflowErr <= 1'b1;
      if (pop) begin
        seq        <= seq + 16'd1;
        FrameCount <= FrameCount + 32'd1;
      end
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state <= S_INIT;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      idx   <= idx_nx;
    end
  end

  // Header byte H[i] sits at hdr_bits[127-8i -: 8]; byte 0 of each word goes on the wire first.
  always_comb begin
    padded         = '0;
    padded[W-1:0]  = mem[rd_ptr];
    hdr_bits       = {DEST_MAC, SRC_MAC, ETHERTYPE, seq};
    hdr_words      = '{default: '0};
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned b = 0; b < 4; b++)
        hdr_words[k][8*b +: 8] = hdr_bits[8*(15 - 4*k - b) +: 8];
    for (int unsigned k = 0; k < NW; k++)
      pay_words[k] = padded[32*k +: 32];
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    idx_nx        = idx;
    RvviAxiWvalid = 1'b0;
    RvviAxiWdata  = '0;
    RvviAxiWstrb  = '0;
    RvviAxiWlast  = 1'b0;
    case (state)
      S_INIT: begin
        if ({1'b0, timer} + 33'd1 >= {1'b0, RVVI_INIT_TIME_OUT}) state_nx = S_IDLE;
        else timer_nx = timer + 32'd1;
      end
      S_IDLE: begin
        if (count != '0) begin
          state_nx = S_HDR;
          idx_nx   = '0;
        end
      end
      S_HDR: begin
        RvviAxiWvalid = 1'b1;
        RvviAxiWdata  = hdr_words[idx[1:0]];
        RvviAxiWstrb  = 4'hF;
        if (RvviAxiWready) begin
          if (idx == IW'(3)) begin
            state_nx = S_PAY;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      S_PAY: begin
        RvviAxiWvalid = 1'b1;
        RvviAxiWdata  = pay_words[idx];
        RvviAxiWstrb  = (idx == LAST_IDX) ? LAST_STRB : 4'hF;
        RvviAxiWlast  = (idx == LAST_IDX);
        if (RvviAxiWready) begin
          if (idx == LAST_IDX) begin
            state_nx = (RVVI_PACKET_DELAY == '0) ? S_IDLE : S_GAP;
            timer_nx = '0;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      S_GAP: begin
        if ({1'b0, timer} + 33'd1 >= {1'b0, RVVI_PACKET_DELAY}) state_nx = S_IDLE;
        else timer_nx = timer + 32'd1;
      end
      default: begin
        state_nx = S_INIT;
        timer_nx = '0;
      end
    endcase
  end

endmodule
